// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending machine controller: selection, coin credit, dispense and refund
//
// Purpose: accepts a three-digit snack selection and coins, holds credit up to
// CREDIT_MAX cents, dispenses when the credit covers the latched price and
// returns change or refunds on cancel. Four states: IDLE, PAY, VEND, REFUND.
// Optional feature: define VEND_TIMEOUT_EN to add an idle-payment timeout of
// TIMEOUT_CYCLES clocks in PAY (refund if credit > 0, else back to IDLE).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in1, in2, in3         selection digits (in1 does not affect the index)
//   sel_valid             selection complete pulse
//   snack_price[10:0]     lookup result: [10] in stock, [9:0] price, 0 = invalid
//   coin_valid, coin_type coin pulse and value code (5/10/25/100 cents)
//   cancel                refund request pulse
//   inventory[39:0]       stock bits fed to the price lookup, 1 = in stock
//   credit[10:0]          accumulated credit in cents
//   vend, vend_idx        dispense pulse and dispensed index
//   change_valid, change  change/refund pulse and amount
//   coin_reject, err_invalid, err_sold_out  one-cycle error pulses

module vend_ctrl #(
    parameter int CREDIT_MAX     = 1000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    input  logic [3:0]  in3,
    input  logic        sel_valid,
    input  logic [10:0] snack_price,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        cancel,
    output logic [39:0] inventory,
    output logic [10:0] credit,
    output logic        vend,
    output logic [5:0]  vend_idx,
    output logic        change_valid,
    output logic [10:0] change,
    output logic        coin_reject,
    output logic        err_invalid,
    output logic        err_sold_out
);

    typedef enum logic [1:0] {S_IDLE, S_PAY, S_VEND, S_REFUND} state_t;

    state_t      state;
    logic [9:0]  price_q;
    logic [5:0]  idx_q;

    // The leading digit only names the machine row family; the index ignores it.
    logic        sel_digit_unused;
    assign sel_digit_unused = ^in1;

    if (TIMEOUT_CYCLES < 2 || CREDIT_MAX > 2047) begin : g_param_check
        $error("vend_ctrl: TIMEOUT_CYCLES must be >= 2 and CREDIT_MAX <= 2047");
    end

    logic [5:0]  sel_idx;
    logic [6:0]  coin_val;
    logic [11:0] coin_sum;
    logic        coin_ok;
    logic [10:0] credit_eff;
    logic        vend_ready;
    logic        sel_accept;

    always_comb begin
        sel_idx = 6'd0;
        case (in2)
            4'd0, 4'd1, 4'd2, 4'd3: sel_idx = {2'b00, in2} * 6'd5 + {3'b000, in3[3:1]};
            4'd4:                   sel_idx = 6'd20 + {2'b00, in3};
            4'd5:                   sel_idx = 6'd30 + {3'b000, in3[3:1]};
            4'd6:                   sel_idx = 6'd35 + {2'b00, in3};
            default:                sel_idx = 6'd0;
        endcase
    end

    always_comb begin
        coin_val = 7'd5;
        case (coin_type)
            2'b00: coin_val = 7'd5;
            2'b01: coin_val = 7'd10;
            2'b10: coin_val = 7'd25;
            2'b11: coin_val = 7'd100;
            default: coin_val = 7'd5;
        endcase
    end

    assign coin_sum   = {1'b0, credit} + {5'b00000, coin_val};
    assign coin_ok    = (coin_sum <= 12'(CREDIT_MAX));
    // Change is paid on the credit including a coin accepted in the same cycle.
    assign credit_eff = (coin_valid && coin_ok) ? coin_sum[10:0] : credit;
    // A selection in PAY takes precedence over dispensing the previous one.
    assign vend_ready = (state == S_PAY) && !sel_valid && (credit >= {1'b0, price_q});
    assign sel_accept = sel_valid && snack_price[10];

`ifdef VEND_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            inventory    <= '1;
            credit       <= '0;
            price_q      <= '0;
            idx_q        <= '0;
            vend         <= 1'b0;
            vend_idx     <= '0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
            err_invalid  <= 1'b0;
            err_sold_out <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            vend         <= 1'b0;
            vend_idx     <= '0;
            change_valid <= 1'b0;
            change       <= '0;
            coin_reject  <= 1'b0;
            err_invalid  <= 1'b0;
            err_sold_out <= 1'b0;

            case (state)
                S_IDLE, S_PAY: begin
                    if (cancel) begin
                        // A coin arriving with cancel is bounced, never refunded.
                        coin_reject <= coin_valid;
                        if (credit != 11'd0) begin
                            state        <= S_REFUND;
                            change_valid <= 1'b1;
                            change       <= credit;
                        end else begin
                            state <= S_IDLE;
                        end
`ifdef VEND_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        if (sel_valid) begin
                            if (snack_price == 11'd0) begin
                                err_invalid <= 1'b1;
                            end else if (!snack_price[10]) begin
                                err_sold_out <= 1'b1;
                            end else begin
                                price_q <= snack_price[9:0];
                                idx_q   <= sel_idx;
                                state   <= S_PAY;
                            end
                        end
                        if (coin_valid) begin
                            if (coin_ok) begin
                                credit <= coin_sum[10:0];
                            end else begin
                                coin_reject <= 1'b1;
                            end
                        end
                        if (vend_ready) begin
                            state        <= S_VEND;
                            vend         <= 1'b1;
                            vend_idx     <= idx_q;
                            change_valid <= 1'b1;
                            change       <= credit_eff - {1'b0, price_q};
                        end
`ifdef VEND_TIMEOUT_EN
                        if (state == S_PAY) begin
                            if (sel_accept || (coin_valid && coin_ok)) begin
                                tmo_cnt <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + 32'd1;
                                if (!vend_ready && tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                                    tmo_cnt <= '0;
                                    if (credit != 11'd0) begin
                                        state        <= S_REFUND;
                                        change_valid <= 1'b1;
                                        change       <= credit;
                                    end else begin
                                        state <= S_IDLE;
                                    end
                                end
                            end
                        end
`endif
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_valid;
                    if (idx_q < 6'd40) begin
                        inventory[idx_q] <= 1'b0;
                    end
                    credit <= '0;
                    state  <= S_IDLE;
`ifdef VEND_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                S_REFUND: begin
                    coin_reject <= coin_valid;
                    credit      <= '0;
                    state       <= S_IDLE;
`ifdef VEND_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - self-checking bench for vend_ctrl

module tb_vend_ctrl;

    localparam int TMO = 16;
    localparam logic [39:0] I0 = 40'hFF_FFFF_FFFF;
    localparam logic [39:0] I1 = 40'hFF_FFFF_FFFE;
    localparam logic [39:0] I2 = 40'h7F_FFFF_FFFE;
    localparam logic [39:0] I3 = 40'h7F_FFFF_FFDE;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in1, in2, in3;
    logic        sel_valid;
    logic [10:0] snack_price;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        cancel;
    logic [39:0] inventory;
    logic [10:0] credit;
    logic        vend;
    logic [5:0]  vend_idx;
    logic        change_valid;
    logic [10:0] change;
    logic        coin_reject, err_invalid, err_sold_out;

    always #5 clk = ~clk;

    vend_ctrl #(.CREDIT_MAX(1000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in3(in3),
        .sel_valid(sel_valid), .snack_price(snack_price),
        .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
        .inventory(inventory), .credit(credit), .vend(vend), .vend_idx(vend_idx),
        .change_valid(change_valid), .change(change), .coin_reject(coin_reject),
        .err_invalid(err_invalid), .err_sold_out(err_sold_out)
    );

    typedef struct packed {
        logic [39:0] inv;
        logic [10:0] credit;
        logic        vend;
        logic [5:0]  vidx;
        logic        cv;
        logic [10:0] chg;
        logic        rej;
        logic        einv;
        logic        esold;
    } out_t;

    typedef struct {
        logic        sel;
        logic [3:0]  d2, d3;
        logic [10:0] price;
        logic        coin;
        logic [1:0]  ct;
        logic        can;
        out_t        exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic out_t mk(logic [39:0] inv, int cr, logic v, int idx, logic cv,
                                int chg, logic rej, logic ei, logic es);
        out_t o;
        o.inv = inv; o.credit = 11'(cr); o.vend = v; o.vidx = 6'(idx); o.cv = cv;
        o.chg = 11'(chg); o.rej = rej; o.einv = ei; o.esold = es;
        return o;
    endfunction

    function automatic vec_t mkv(logic s, int d2, int d3, logic [10:0] p, logic c,
                                 int ct, logic can, out_t e);
        vec_t v;
        v.sel = s; v.d2 = 4'(d2); v.d3 = 4'(d3); v.price = p; v.coin = c;
        v.ct = 2'(ct); v.can = can; v.exp = e;
        return v;
    endfunction

    function automatic out_t cur();
        out_t o;
        o.inv = inventory; o.credit = credit; o.vend = vend; o.vidx = vend_idx;
        o.cv = change_valid; o.chg = change; o.rej = coin_reject;
        o.einv = err_invalid; o.esold = err_sold_out;
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("inv=%h credit=%0d vend=%b idx=%0d cv=%b chg=%0d rej=%b einv=%b esold=%b",
                         o.inv, o.credit, o.vend, o.vidx, o.cv, o.chg, o.rej, o.einv, o.esold);
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = cur();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input int d2, input int d3, input logic [10:0] p,
                         input logic c, input int ct, input logic can);
        sel_valid = s; in2 = 4'(d2); in3 = 4'(d3); in1 = 4'($urandom_range(0, 9));
        snack_price = p; coin_valid = c; coin_type = 2'(ct); cancel = can;
        @(posedge clk);
        #1;
        sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 11'd0, 1'b0, 0, 1'b0);
    endtask

    // ---------------- reference model ----------------
    // Tracks what the customer has done: credit in hand, whether a product is
    // chosen, and whether the machine is busy paying out this cycle.
    bit [39:0] m_inv;
    int        m_credit, m_price, m_idx, m_wait;
    bit        m_selected, m_dispensing, m_refunding;

    function automatic int coin_cents(int ct);
        case (ct)
            0: return 5;
            1: return 10;
            2: return 25;
            default: return 100;
        endcase
    endfunction

    function automatic int idx_of(int d2, int d3);
        if (d2 < 4) return d2 * 5 + d3 / 2;
        if (d2 == 4) return 20 + d3;
        if (d2 == 5) return 30 + d3 / 2;
        return 35 + d3;
    endfunction

    task automatic model_reset();
        m_inv = '1; m_credit = 0; m_price = 0; m_idx = 0; m_wait = 0;
        m_selected = 0; m_dispensing = 0; m_refunding = 0;
    endtask

    task automatic model_step(input bit sel, input int idx, input logic [10:0] price,
                              input bit coin, input int cval, input bit can, output out_t e);
        int old_credit, old_price;
        bit was_pay, took;
        old_credit = m_credit; old_price = m_price; was_pay = m_selected; took = 0;
        e = '0;
        if (m_dispensing) begin
            if (m_idx < 40) m_inv[m_idx] = 1'b0;
            m_credit = 0; m_dispensing = 0; m_selected = 0; e.rej = coin;
        end else if (m_refunding) begin
            m_credit = 0; m_refunding = 0; m_selected = 0; e.rej = coin;
        end else if (can) begin
            e.rej = coin; m_wait = 0; m_selected = 0;
            if (m_credit > 0) begin
                m_refunding = 1; e.cv = 1; e.chg = 11'(m_credit);
            end
        end else begin
            if (sel) begin
                if (price == 11'd0) e.einv = 1;
                else if (!price[10]) e.esold = 1;
                else begin
                    m_price = int'(price[9:0]); m_idx = idx; m_selected = 1; took = 1;
                end
            end
            if (coin) begin
                if (m_credit + cval <= 1000) begin
                    m_credit += cval; took = 1;
                end else e.rej = 1;
            end
            if (was_pay && !sel && old_credit >= old_price) begin
                m_dispensing = 1; e.vend = 1; e.vidx = 6'(m_idx); e.cv = 1;
                e.chg = 11'(m_credit - old_price); m_wait = 0;
            end
`ifdef VEND_TIMEOUT_EN
            else if (was_pay) begin
                if (took) m_wait = 0;
                else if (m_wait == TMO - 1) begin
                    m_wait = 0; m_selected = 0;
                    if (m_credit > 0) begin
                        m_refunding = 1; e.cv = 1; e.chg = 11'(m_credit);
                    end
                end else m_wait++;
            end else m_wait = 0;
`endif
        end
        e.inv = m_inv; e.credit = 11'(m_credit);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        out_t e;
        rst = 1'b1; in1 = 0; in2 = 0; in3 = 0; sel_valid = 0; snack_price = 0;
        coin_valid = 0; coin_type = 0; cancel = 0;

        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 3, 0, mk(I0, 100, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 0, 11'h464, 0, 0, 0, mk(I0, 100, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I0, 100, 1, 0, 1, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 0, 11'h064, 0, 0, 0, mk(I1, 0, 0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkv(1, 7, 0, 11'h000, 0, 0, 0, mk(I1, 0, 0, 0, 0, 0, 0, 1, 0)));
        tbl.push_back(mkv(1, 6, 4, 11'h419, 0, 0, 0, mk(I1, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 3, 0, mk(I1, 100, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I1, 100, 1, 39, 1, 75, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I2, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 2, 0, mk(I2, 25, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 2, 0, mk(I2, 50, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 2, 1, mk(I2, 50, 0, 0, 1, 50, 1, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I2, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 1, mk(I2, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 1, 0, 11'h4C8, 1, 3, 0, mk(I2, 100, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 3, 0, mk(I2, 200, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 0, 0, 0, mk(I2, 200, 1, 5, 1, 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 0, 11'h000, 1, 3, 0, mk(I3, 0, 0, 0, 0, 0, 1, 0, 0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset", mk(I0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, int'(tbl[i].d2), int'(tbl[i].d3), tbl[i].price,
                  tbl[i].coin, int'(tbl[i].ct), tbl[i].can);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // credit cap
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 11'h0, 1, 3, 0);
        check("cap_full", mk(I3, 1000, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 11'h0, 1, 0, 0);
        check("cap_reject", mk(I3, 1000, 0, 0, 0, 0, 1, 0, 0));
        drive(0, 0, 0, 11'h0, 0, 0, 1);
        check("cap_refund", mk(I3, 1000, 0, 0, 1, 1000, 0, 0, 0));
        idle();
        check("cap_clear", mk(I3, 0, 0, 0, 0, 0, 0, 0, 0));

        // asynchronous reset in the middle of PAY
        drive(0, 0, 0, 11'h0, 1, 3, 0);
        drive(1, 2, 2, 11'h5F4, 0, 0, 0);
        check("pay_pending", mk(I3, 100, 0, 0, 0, 0, 0, 0, 0));
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", mk(I0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("rst_quiet", mk(I0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

`ifdef VEND_TIMEOUT_EN
        drive(1, 3, 4, 11'h4C8, 0, 0, 0);
        drive(0, 0, 0, 11'h0, 1, 2, 0);
        check("tmo_credit", mk(I0, 25, 0, 0, 0, 0, 0, 0, 0));
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (change_valid) begin
                k = i;
                break;
            end
        end
        check_int("tmo_cycles", k, TMO);
        check("tmo_refund", mk(I0, 25, 0, 0, 1, 25, 0, 0, 0));
        idle();
        check("tmo_clear", mk(I0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            bit s, c, can;
            int d2, d3, idx, ct;
            logic [10:0] p;
            if (n % 500 == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
            end
            s   = ($urandom_range(0, 9) == 0);
            d2  = $urandom_range(0, 6);
            d3  = $urandom_range(0, 9);
            idx = idx_of(d2, d3);
            if ($urandom_range(0, 7) == 0) p = 11'd0;
            else p = {(idx >= 40) ? 1'b1 : m_inv[idx], 10'(5 + 5 * (idx % 20))};
            c   = ($urandom_range(0, 2) == 0);
            ct  = $urandom_range(0, 3);
            can = ($urandom_range(0, 24) == 0);
            model_step(s, idx, p, c, coin_cents(ct), can, e);
            drive(s, d2, d3, p, c, ct, can);
            check("rand", e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
